// File: rtl/ram_param_clr.sv
// Parametrised single-port synchronous RAM with a hardware zero-fill
// sequencer. The sweep runs after reset and whenever clear is seen while
// idle. Out-of-range accesses are flagged for one cycle through addr_err.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_SWEEP | zero-filling mem[ptr] one word per edge, user accesses ignored
// ST_IDLE  | array usable; reads, writes and clear requests are honoured
module ram_param_clr #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 10,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clear,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              addr_err
);

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // DEPTH widened by one bit so the range compare never overflows.
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                addr_err_q, addr_err_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic                addr_ok;
    logic                is_access;
    logic [DATA_W-1:0]   rd_word;

    // Address qualification; a gated write (we=1, enable=0) is not an access.
    always_comb begin
        addr_ok   = ({1'b0, addr} < DEPTH_C);
        is_access = !we || enable;
        rd_word   = '0;
        if (addr_ok) begin
            rd_word = mem_q[addr];
        end
    end

    // Next-state, sweep pointer, array write port and registered outputs.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        data_out_d = data_out_q;
        addr_err_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = ptr_q;
        mem_wdata  = '0;
        unique case (state_q)
            ST_SWEEP: begin
                mem_we = 1'b1;
                if (ptr_q == LAST_C) begin
                    ptr_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    // Clear wins over any access presented in the same cycle.
                    ptr_d   = '0;
                    state_d = ST_SWEEP;
                end else if (is_access) begin
                    addr_err_d = !addr_ok;
                    if (we && addr_ok) begin
                        mem_we    = 1'b1;
                        mem_waddr = addr;
                        mem_wdata = data_in;
                    end
                    if (!we) begin
                        data_out_d = addr_ok ? rd_word : '0;
                    end
                end
            end
            default: begin
                state_d = ST_SWEEP;
                ptr_d   = '0;
            end
        endcase
    end

    // Control and output registers; reset restarts the sweep from word 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_SWEEP;
            ptr_q      <= '0;
            data_out_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            data_out_q <= data_out_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Storage array; deliberately not reset, the sweep zeroes it instead.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign data_out = data_out_q;
    assign addr_err = addr_err_q;
    assign busy     = (state_q == ST_SWEEP);

endmodule

// File: tb/tb_ram_param_clr.sv
// Bench for ram_param_clr: directed vector table, hand-written clear and
// reset corner sequences, then random traffic against a behavioural model.
module tb_ram_param_clr;

    localparam int DATA_W = 3;
    localparam int DEPTH  = 10;
    localparam int ADDR_W = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic              clear = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic              addr_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: array contents, output register, remaining busy edges.
    int m_mem [DEPTH];
    int m_dout;
    int m_err;
    int m_left;

    ram_param_clr #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .clear    (clear),
        .data_out (data_out),
        .busy     (busy),
        .addr_err (addr_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic c, w, e;
        int   a, d;
        int   exp_dout, exp_busy, exp_err;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        m_dout = 0;
        m_err  = 0;
        m_left = DEPTH;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".data_out"}, int'(data_out), m_dout);
        chk({tag, ".busy"}, int'(busy), (m_left > 0) ? 1 : 0);
        chk({tag, ".addr_err"}, int'(addr_err), m_err);
    endtask

    // One clock: drive at negedge, update the model at posedge, check at negedge.
    task automatic cycle(input logic c, input logic w, input logic e,
                         input int a, input int d, input string tag);
        clear   = c;
        we      = w;
        enable  = e;
        addr    = ADDR_W'(a);
        data_in = DATA_W'(d);
        @(posedge clock);
        if (m_left > 0) begin
            m_left--;
            m_err = 0;
        end else if (c) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
            m_left = DEPTH;
            m_err  = 0;
        end else begin
            m_err = ((!w || e) && a >= DEPTH) ? 1 : 0;
            if (w && e && a < DEPTH) m_mem[a] = d;
            if (!w) m_dout = (a < DEPTH) ? m_mem[a] : 0;
        end
        @(negedge clock);
        chk_model(tag);
    endtask

    vec_t vecs [$];
    int   busy_edges;

    initial begin
        // Directed vectors, applied after the power-up sweep (array all zero).
        vecs.push_back('{1'b0, 1'b1, 1'b1,  3, 5, 0, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b0,  3, 0, 5, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1,  9, 7, 5, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1,  9, 0, 7, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1,  2, 6, 7, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0,  2, 1, 7, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b0,  2, 0, 6, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 12, 4, 6, 0, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 15, 0, 0, 0, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b0,  3, 0, 5, 0, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 13, 2, 5, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1,  9, 0, 7, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b0,  2, 0, 6, 0, 0});

        // Reset state, sampled while reset is still high.
        model_reset();
        #12;
        chk("reset.data_out", int'(data_out), 0);
        chk("reset.busy", int'(busy), 1);
        chk("reset.addr_err", int'(addr_err), 0);
        @(negedge clock);
        reset = 1'b0;

        // Power-up sweep: count busy edges, ignoring junk accesses.
        busy_edges = 0;
        for (int i = 0; i < 30 && busy; i++) begin
            cycle(1'b0, 1'b1, 1'b1, i % DEPTH, 7, "sweep0");
            busy_edges++;
        end
        chk("sweep0.busy_edges", busy_edges, DEPTH);
        for (int a = 0; a < DEPTH; a++) begin
            cycle(1'b0, 1'b0, 1'b0, a, 0, "sweep0.read");
            chk("sweep0.read_zero", int'(data_out), 0);
        end

        // Table-driven directed checks.
        foreach (vecs[i]) begin
            cycle(vecs[i].c, vecs[i].w, vecs[i].e, vecs[i].a, vecs[i].d, "vec.model");
            chk($sformatf("vec%0d.data_out", i), int'(data_out), vecs[i].exp_dout);
            chk($sformatf("vec%0d.busy", i), int'(busy), vecs[i].exp_busy);
            chk($sformatf("vec%0d.addr_err", i), int'(addr_err), vecs[i].exp_err);
        end

        // Clear colliding with a write; accesses during the sweep are ignored.
        for (int a = 0; a < DEPTH; a++) cycle(1'b0, 1'b1, 1'b1, a, 3, "fill");
        cycle(1'b1, 1'b1, 1'b1, 4, 7, "clr.collide");
        chk("clr.busy_after", int'(busy), 1);
        busy_edges = 0;
        for (int i = 0; i < 30 && busy; i++) begin
            cycle(1'b0, i[0], 1'b1, (i * 3) % 16, 5, "clr.sweep");
            busy_edges++;
        end
        chk("clr.busy_edges", busy_edges, DEPTH);
        for (int a = 0; a < DEPTH; a++) begin
            cycle(1'b0, 1'b0, 1'b1, a, 0, "clr.read");
            chk("clr.read_zero", int'(data_out), 0);
        end

        // Reset in the middle of a clear sweep; data_out drops asynchronously.
        cycle(1'b0, 1'b1, 1'b1, 3, 5, "mid.wr");
        cycle(1'b0, 1'b0, 1'b0, 3, 0, "mid.rd");
        chk("mid.pre_dout", int'(data_out), 5);
        cycle(1'b1, 1'b0, 1'b0, 0, 0, "mid.clear");
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 0, 0, "mid.sweep");
        chk("mid.hold_dout", int'(data_out), 5);
        #2;
        reset = 1'b1;
        #1;
        chk("mid.async_dout", int'(data_out), 0);
        chk("mid.async_busy", int'(busy), 1);
        chk("mid.async_err", int'(addr_err), 0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        busy_edges = 0;
        for (int i = 0; i < 30 && busy; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 0, 0, "mid.resweep");
            busy_edges++;
        end
        chk("mid.busy_edges", busy_edges, DEPTH);
        for (int a = 0; a < DEPTH; a++) begin
            cycle(1'b0, 1'b0, 1'b0, a, 0, "mid.read");
            chk("mid.read_zero", int'(data_out), 0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 25) == 0, $urandom % 2, $urandom % 2,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
